// File: rtl/video_sync_gen.sv
// Composite sync generator: two-field line/column timing with inverted-serration
// vertical sync, a colour-burst gate and a small test-target rectangle.
module video_sync_gen #(
  parameter int unsigned H_TOTAL      = 254,
  parameter int unsigned H_SYNC       = 19,
  parameter int unsigned BURST_START  = 21,
  parameter int unsigned BURST_LEN    = 10,
  parameter int unsigned V_SYNC_LINES = 3,
  parameter int unsigned LINES_F0     = 263,
  parameter int unsigned LINES_F1     = 262,
  parameter int unsigned TGT_LINE     = 140,
  parameter int unsigned TGT_COL      = 140,
  parameter int unsigned TGT_H        = 7,
  parameter int unsigned TGT_W        = 3
) (
  input  logic       clk4mhz,
  input  logic       reset,
  input  logic       en,
  output logic       csync,
  output logic       vsync,
  output logic       burst,
  output logic       field,
  output logic       video,
  output logic       frame_start,
  output logic [8:0] line_cnt,
  output logic [8:0] col_cnt
);

  logic [8:0]  r_hcount;
  logic [8:0]  r_vcount;
  logic        r_field;

  logic [31:0] w_h;
  logic [31:0] w_v;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_vs_line;
  logic        w_csync;
  logic        w_burst;
  logic        w_tgt_rows;
  logic        w_tgt_cols;
  logic        w_video;
  logic        w_frame_start;

  assign w_h = {23'd0, r_hcount};
  assign w_v = {23'd0, r_vcount};

  assign w_h_last  = (w_h == H_TOTAL - 1);
  assign w_v_last  = r_field ? (w_v == LINES_F1 - 1) : (w_v == LINES_F0 - 1);
  assign w_vs_line = (w_v < V_SYNC_LINES);

  // Vsync lines carry inverted serration: high except for the last H_SYNC clocks.
  assign w_csync = w_vs_line ? (w_h < H_TOTAL - H_SYNC) : (w_h < H_SYNC);

  assign w_burst = !w_vs_line && (w_h >= BURST_START) &&
                   (w_h < BURST_START + BURST_LEN);

  assign w_tgt_rows    = (w_v >= TGT_LINE) && (w_v < TGT_LINE + TGT_H);
  assign w_tgt_cols    = (w_h >= TGT_COL) && (w_h < TGT_COL + TGT_W);
  assign w_video       = w_tgt_rows && w_tgt_cols && !w_vs_line && !w_csync;
  assign w_frame_start = (r_hcount == 9'd0) && (r_vcount == 9'd0);

  always_ff @(posedge clk4mhz) begin
    if (reset || !en) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_field  <= 1'b0;
    end else if (w_h_last) begin
      r_hcount <= '0;
      if (w_v_last) begin
        r_vcount <= '0;
        r_field  <= ~r_field;
      end else begin
        r_vcount <= r_vcount + 9'd1;
      end
    end else begin
      r_hcount <= r_hcount + 9'd1;
    end
  end

  // Outputs are one cycle behind the counters they describe.
  always_ff @(posedge clk4mhz) begin
    if (reset || !en) begin
      csync       <= 1'b0;
      vsync       <= 1'b0;
      burst       <= 1'b0;
      field       <= 1'b0;
      video       <= 1'b0;
      frame_start <= 1'b0;
      line_cnt    <= '0;
      col_cnt     <= '0;
    end else begin
      csync       <= w_csync;
      vsync       <= w_vs_line;
      burst       <= w_burst;
      field       <= r_field;
      video       <= w_video;
      frame_start <= w_frame_start;
      line_cnt    <= r_vcount;
      col_cnt     <= r_hcount;
    end
  end

endmodule

// File: tb/tb_video_sync_gen.sv
// Directed bench for video_sync_gen: reset, mid-line reset, one full field of
// timing measurements, field toggle, enable drop, plus a tiny-geometry instance.
module tb_video_sync_gen;

  logic       clk4mhz = 1'b0;
  logic       reset;
  logic       en;

  logic       csync, vsync, burst, field, video, frame_start;
  logic [8:0] line_cnt, col_cnt;
  logic       s_csync, s_vsync, s_burst, s_field, s_video, s_frame_start;
  logic [8:0] s_line_cnt, s_col_cnt;

  logic [22:0] all_outs;
  logic [22:0] s_all_outs;

  int n_checks = 0;
  int n_fail   = 0;

  always #125 clk4mhz = ~clk4mhz;

  video_sync_gen u_dut (
    .clk4mhz    (clk4mhz),
    .reset      (reset),
    .en         (en),
    .csync      (csync),
    .vsync      (vsync),
    .burst      (burst),
    .field      (field),
    .video      (video),
    .frame_start(frame_start),
    .line_cnt   (line_cnt),
    .col_cnt    (col_cnt)
  );

  // Small geometry: field 0 = 5*32 = 160 clocks, field 1 = 4*32 = 128 clocks.
  video_sync_gen #(
    .H_TOTAL(32), .H_SYNC(4), .BURST_START(6), .BURST_LEN(3),
    .V_SYNC_LINES(2), .LINES_F0(5), .LINES_F1(4),
    .TGT_LINE(3), .TGT_COL(10), .TGT_H(1), .TGT_W(2)
  ) u_small (
    .clk4mhz    (clk4mhz),
    .reset      (reset),
    .en         (en),
    .csync      (s_csync),
    .vsync      (s_vsync),
    .burst      (s_burst),
    .field      (s_field),
    .video      (s_video),
    .frame_start(s_frame_start),
    .line_cnt   (s_line_cnt),
    .col_cnt    (s_col_cnt)
  );

  assign all_outs   = {csync, vsync, burst, field, video, frame_start, line_cnt, col_cnt};
  assign s_all_outs = {s_csync, s_vsync, s_burst, s_field, s_video, s_frame_start,
                       s_line_cnt, s_col_cnt};

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end else begin
      $display("ok   %s = %0d", tag, act);
    end
  endtask

  initial begin
    int found;
    int len, done;
    int prev_c, prev_b, last_rise;
    int n_vs, n_vs_ch, n_vs_burst, n_cs_hi, n_burst_hi, n_rises, n_bad_period;
    int n_burst_rises, n_bad_burst_ofs, n_vid, n_vid_bad, n_vid_pos, n_field1;
    int s_last, s_prev_field, s_n, s_bad;
    int lc, cc;

    reset = 1'b1;
    en    = 1'b1;
    repeat (4) @(negedge clk4mhz);
    check_val("reset_outs", int'(all_outs), 0);
    check_val("reset_small_outs", int'(s_all_outs), 0);

    // First edge after release samples counters at (0,0) in field 0.
    reset = 1'b0;
    @(negedge clk4mhz);
    check_val("first_frame_start", int'(frame_start), 1);
    check_val("first_line", int'(line_cnt), 0);
    check_val("first_col", int'(col_cnt), 0);
    check_val("first_vsync", int'(vsync), 1);
    check_val("first_csync", int'(csync), 1);
    check_val("first_field", int'(field), 0);

    found = 0;
    for (int i = 0; i < 25000 && found == 0; i++) begin
      @(negedge clk4mhz);
      if (line_cnt == 9'd77 && col_cnt == 9'd200) found = 1;
    end
    check_val("reach_line77_col200", found, 1);
    check_val("line77_csync", int'(csync), 0);

    reset = 1'b1;
    @(negedge clk4mhz);
    check_val("midrst_outs", int'(all_outs), 0);
    reset = 1'b0;
    @(negedge clk4mhz);
    check_val("midrst_frame_start", int'(frame_start), 1);
    check_val("midrst_line", int'(line_cnt), 0);
    check_val("midrst_col", int'(col_cnt), 0);

    // Step 0 of a fresh field 0 is the current sample; walk until the next frame_start.
    len = 0; done = 0;
    prev_c = 0; prev_b = 0; last_rise = -1;
    n_vs = 0; n_vs_ch = 0; n_vs_burst = 0; n_cs_hi = 0; n_burst_hi = 0;
    n_rises = 0; n_bad_period = 0; n_burst_rises = 0; n_bad_burst_ofs = 0;
    n_vid = 0; n_vid_bad = 0; n_vid_pos = 0; n_field1 = 0;
    s_last = 0; s_prev_field = 0; s_n = 0; s_bad = 0;
    for (int i = 0; i < 70000 && done == 0; i++) begin
      if (i > 0) begin
        @(negedge clk4mhz);
        if (frame_start) begin
          done = 1;
          len  = i;
        end
      end
      if (done == 0) begin
        lc = int'(line_cnt);
        cc = int'(col_cnt);
        if (vsync) begin
          n_vs++;
          if (csync) n_vs_ch++;
          if (burst) n_vs_burst++;
        end else begin
          if (csync) n_cs_hi++;
          if (burst) n_burst_hi++;
          if (csync && prev_c == 0) begin
            if (last_rise >= 0 && i - last_rise != 254) n_bad_period++;
            n_rises++;
            last_rise = i;
          end
          if (burst && prev_b == 0) begin
            n_burst_rises++;
            if (i - last_rise != 21) n_bad_burst_ofs++;
          end
        end
        if (video) begin
          n_vid++;
          if (vsync || csync) n_vid_bad++;
          if (lc < 140 || lc > 146 || cc < 140 || cc > 142) n_vid_pos++;
        end
        if (field) n_field1++;
        prev_c = int'(csync);
        prev_b = int'(burst);

        if (s_frame_start) begin
          if (i > 0) begin
            s_n++;
            if (i - s_last != (s_prev_field != 0 ? 128 : 160)) s_bad++;
            if (int'(s_field) == s_prev_field) s_bad++;
          end
          s_last       = i;
          s_prev_field = int'(s_field);
        end
      end
    end

    check_val("field0_done", done, 1);
    check_val("field0_len", len, 66802);
    check_val("field_toggle", int'(field), 1);
    check_val("field1_start_line", int'(line_cnt), 0);
    check_val("field0_level", n_field1, 0);
    check_val("vsync_clocks", n_vs, 762);
    check_val("vsync_csync_high", n_vs_ch, 705);
    check_val("vsync_burst", n_vs_burst, 0);
    check_val("csync_rises", n_rises, 260);
    check_val("csync_period_bad", n_bad_period, 0);
    check_val("csync_high_clocks", n_cs_hi, 4940);
    check_val("burst_high_clocks", n_burst_hi, 2600);
    check_val("burst_rises", n_burst_rises, 260);
    check_val("burst_offset_bad", n_bad_burst_ofs, 0);
    check_val("video_count", n_vid, 21);
    check_val("video_in_sync", n_vid_bad, 0);
    check_val("video_outside_target", n_vid_pos, 0);
    check_val("small_fs_count", s_n, 463);
    check_val("small_field_len_bad", s_bad, 0);

    repeat (300) @(negedge clk4mhz);
    check_val("field1_level", int'(field), 1);
    check_val("field1_line", int'(line_cnt), 1);

    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk4mhz);
      check_val("endrop_outs", int'(all_outs), 0);
    end
    en = 1'b1;
    @(negedge clk4mhz);
    check_val("enrestore_frame_start", int'(frame_start), 1);
    check_val("enrestore_field", int'(field), 0);
    check_val("enrestore_line", int'(line_cnt), 0);
    check_val("enrestore_col", int'(col_cnt), 0);
    @(negedge clk4mhz);
    check_val("enrestore_col_next", int'(col_cnt), 1);
    check_val("enrestore_fs_next", int'(frame_start), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_sync_gen.md
VIDEO_SYNC_GEN -- requirements
Module: video_sync_gen

Interface
Parameters:
REQ-001 The block SHALL have parameter H_TOTAL, default 254, meaning clocks per line.
REQ-002 The block SHALL have parameter H_SYNC, default 19, meaning the horizontal sync pulse width in clocks.
REQ-003 The block SHALL have parameter BURST_START, default 21, meaning the first hcount at which burst is high.
REQ-004 The block SHALL have parameter BURST_LEN, default 10, meaning the burst width in clocks.
REQ-005 The block SHALL have parameter V_SYNC_LINES, default 3, meaning the number of vertical sync lines at the start of each field.
REQ-006 The block SHALL have parameter LINES_F0, default 263, meaning lines in field 0.
REQ-007 The block SHALL have parameter LINES_F1, default 262, meaning lines in field 1.
REQ-008 The block SHALL have parameters TGT_LINE, TGT_COL, TGT_H and TGT_W, defaults 140, 140, 7 and 3, meaning the position and size of the test target rectangle.
Ports:
REQ-009 The block SHALL have input clk4mhz, 1 bit: the 4 MHz system clock; one clock and all logic on its rising edge.
REQ-010 The block SHALL have input reset, 1 bit: reset is synchronous and active-high.
REQ-011 The block SHALL have input en, 1 bit: run enable.
REQ-012 The block SHALL have output csync, 1 bit: composite sync, high during the sync pulse.
REQ-013 The block SHALL have output vsync, 1 bit: high for the whole of each vertical sync line.
REQ-014 The block SHALL have output burst, 1 bit: colour burst gate.
REQ-015 The block SHALL have output field, 1 bit: current field, 0 or 1.
REQ-016 The block SHALL have output video, 1 bit: test target pixel, high when the target is active.
REQ-017 The block SHALL have output frame_start, 1 bit: one-cycle strobe at line 0, column 0.
REQ-018 The block SHALL have outputs line_cnt [8:0] and col_cnt [8:0]: the registered vcount and hcount.

Function
REQ-019 The block SHALL keep an internal hcount that runs 0..H_TOTAL-1 and wraps to 0; each wrap SHALL increment vcount.
REQ-020 vcount SHALL wrap to 0 after LINES_F0-1 when field=0 and after LINES_F1-1 when field=1; field SHALL toggle on each vcount wrap.
REQ-021 Every output SHALL be registered, so each output in cycle n+1 reflects the counter values of cycle n (latency 1).
REQ-022 On normal lines (vcount >= V_SYNC_LINES), csync SHALL be high only for hcount 0..H_SYNC-1.
REQ-023 On vsync lines (vcount < V_SYNC_LINES), vsync SHALL be high, and csync SHALL use inverted serration: high for hcount 0..H_TOTAL-H_SYNC-1 and low for the last H_SYNC clocks.
REQ-024 burst SHALL be high for hcount BURST_START..BURST_START+BURST_LEN-1 on normal lines only, and low on vsync lines.
REQ-025 video SHALL be high iff vcount is in TGT_LINE..TGT_LINE+TGT_H-1, hcount is in TGT_COL..TGT_COL+TGT_W-1, the line is a normal line, and csync would be low.
REQ-026 frame_start SHALL pulse for one cycle when hcount=0 and vcount=0, in both fields.
REQ-027 When en=0 for one or more cycles, hcount, vcount and field SHALL clear to 0, and all outputs SHALL be 0 on the following cycle.
REQ-028 When en rises, the counters SHALL start at line 0, column 0, field 0; the first frame_start SHALL appear one cycle after en is first sampled high.
REQ-029 Parameter legality: H_SYNC < BURST_START, BURST_START+BURST_LEN <= H_TOTAL, and LINES_F0 <= 511; an illegal combination SHALL be a configuration error that the block does not check.

Reset
REQ-030 While reset=1, the block SHALL hold hcount, vcount and field at 0, and drive csync, vsync, burst, video, frame_start, line_cnt and col_cnt at 0.
REQ-031 reset SHALL take priority over en.
REQ-032 A reset asserted mid-line or mid-field SHALL abandon the current line; after release the sequence SHALL restart exactly as from power-up.

Verification
REQ-033 Scenario "free run": release reset with en=1 and measure the csync rising edges on normal lines. Required: period 254 clocks, high width 19 clocks, burst high for 10 clocks starting 21 clocks after the csync rise.
REQ-034 Scenario "field timing": run two fields. Required: field 0 lasts 66802 clocks and field 1 lasts 66548 clocks; field toggles at each frame_start; each field has 762 clocks of vsync high with serrated csync (235 clocks high, 19 clocks low per line).
REQ-035 Scenario "target": run one full field with default parameters. Required: video is high on exactly 21 cycles, on lines 140..146 at col_cnt 140..142, and never during vsync or csync high.
REQ-036 Scenario "mid-operation reset": assert reset for 1 cycle at line 77, column 200. Required: all outputs read 0 on the next cycle, and frame_start fires one cycle after release.
REQ-037 Scenario "enable drop": drop en for 5 cycles during field 1, then restore it. Required: all outputs are 0 during the drop, and after restore field=0, line_cnt=0, col_cnt=0, with a frame_start pulse.
REQ-038 Scenario "loopback": feed csync and vsync into the existing receiver line and column counters. Required: the receiver line count reaches 262 or 263 per field, and its column count restarts after each csync pulse.
